// File: rtl/tow_pkg.sv
// Shared types and sizing helpers for the tug-of-war playfield.
package tow_pkg;

   typedef enum logic {PLAY, OUT} state_t;

   function automatic int center(input int n);
      return (n + 1) / 2;
   endfunction

   // Positions run 0..n+1, where 0 and n+1 are the two off-field exits.
   function automatic int pos_w(input int n);
      return $clog2(n + 2);
   endfunction

endpackage

// File: rtl/tow_playfield_key_pulse.sv
// Button conditioner: 2-flop synchronizer, history flop and registered rise pulse.
module key_pulse (
   input  logic Clock,
   input  logic Reset,
   input  logic raw,
   output logic rise
);

   logic s1, s2, s3;

   // History resets high so a button held through reset never looks like a press.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         s3   <= 1'b1;
         rise <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
      end
   end

endmodule

// File: rtl/tow_playfield.sv
// Tug-of-war playfield: conditions both buttons, moves the light and flags the exit.
module tow_playfield
   import tow_pkg::*;
#(
   parameter int NUM_LEDS = 9,
   parameter int CENTER   = center(NUM_LEDS)
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                L_raw,
   input  logic                R_raw,
   output logic                L,
   output logic                R,
   output logic [NUM_LEDS-1:0] leds,
   output logic                done
);

   localparam int              PW       = pos_w(NUM_LEDS);
   localparam logic [PW-1:0]   POS_C    = PW'(CENTER);
   localparam logic [PW-1:0]   POS_LEFT = PW'(NUM_LEDS + 1);

   logic [1:0] raw, rise;
   logic       rise_l, rise_r;

   assign raw    = {L_raw, R_raw};
   assign rise_l = rise[1];
   assign rise_r = rise[0];

   for (genvar b = 0; b < 2; b++) begin : g_key
      key_pulse u_key (
         .Clock (Clock),
         .Reset (Reset),
         .raw   (raw[b]),
         .rise  (rise[b])
      );
   end

   state_t                state, state_n;
   logic [PW-1:0]         pos, pos_n;
   logic                  l_n, r_n, done_n;
   logic [NUM_LEDS-1:0]   leds_n;

   // The move uses the registered pulse, so leds keeps the pre-move position while L/R is high.
   always_comb begin
      state_n = state;
      pos_n   = pos;
      l_n     = 1'b0;
      r_n     = 1'b0;
      leds_n  = '0;
      if (state == PLAY) begin
         if (L)
            pos_n = pos + 1'b1;
         else if (R)
            pos_n = pos - 1'b1;
         if (pos_n == '0 || pos_n == POS_LEFT)
            state_n = OUT;
         if (state_n == PLAY) begin
            l_n = rise_l & ~rise_r;
            r_n = rise_r & ~rise_l;
         end
      end
      for (int i = 0; i < NUM_LEDS; i++)
         leds_n[i] = (pos_n == PW'(i + 1));
      done_n = (state_n == OUT);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= PLAY;
         pos   <= POS_C;
         L     <= 1'b0;
         R     <= 1'b0;
         leds  <= NUM_LEDS'(1) << (CENTER - 1);
         done  <= 1'b0;
      end else begin
         state <= state_n;
         pos   <= pos_n;
         L     <= l_n;
         R     <= r_n;
         leds  <= leds_n;
         done  <= done_n;
      end
   end

endmodule

// File: tb/tb_tow_playfield.sv
// Directed vector bench for tow_playfield: table rows plus hand-written exit sequences.
module tb_tow_playfield;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       L_raw = 1'b0;
   logic       R_raw = 1'b0;
   logic       L, R, done;
   logic [8:0] leds;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [8:0] C  = 9'b000010000;
   localparam logic [8:0] P6 = 9'b000100000;
   localparam logic [8:0] P4 = 9'b000001000;

   typedef struct {
      bit         rst, l, r, el, er;
      logic [8:0] eleds;
      bit         edone;
   } vec_t;

   vec_t tbl[$];

   tow_playfield #(.NUM_LEDS(9)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .L_raw (L_raw),
      .R_raw (R_raw),
      .L     (L),
      .R     (R),
      .leds  (leds),
      .done  (done)
   );

   always #5 Clock = ~Clock;

   function automatic void add(bit rst, bit l, bit r, bit el, bit er, logic [8:0] eleds, bit edone);
      vec_t v;
      v.rst = rst; v.l = l; v.r = r; v.el = el; v.er = er; v.eleds = eleds; v.edone = edone;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1; L_raw = 1'b0; R_raw = 1'b0;
      step();
      chk("reset_leds", 32'(leds), 32'(C));
      chk("reset_done", 32'(done), 32'd0);
      Reset = 1'b0;
      repeat (3) step();
   endtask

   // One press of a button: pulse in the 4th cycle with pre-move leds, move on the next edge.
   task automatic press(input bit left, input logic [8:0] pre, input logic [8:0] post, input bit pdone);
      if (left) L_raw = 1'b1; else R_raw = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("press_early", 32'({L, R}), 32'd0);
      end
      step();
      chk("press_pulse", 32'({L, R}), left ? 32'd2 : 32'd1);
      chk("press_pre_leds", 32'(leds), 32'(pre));
      step();
      chk("press_after", 32'({L, R}), 32'd0);
      chk("press_post_leds", 32'(leds), 32'(post));
      chk("press_done", 32'(done), 32'(pdone));
      L_raw = 1'b0; R_raw = 1'b0;
      repeat (2) step();
   endtask

   initial begin
      // Reset, then idle long enough for the synchronizers to drain.
      repeat (4) add(1, 0, 0, 0, 0, C, 0);
      repeat (3) add(0, 0, 0, 0, 0, C, 0);
      // L held 10 cycles: one pulse after the 4th edge, move on the 5th.
      repeat (3) add(0, 1, 0, 0, 0, C, 0);
      add(0, 1, 0, 1, 0, C, 0);
      repeat (6) add(0, 1, 0, 0, 0, P6, 0);
      repeat (2) add(0, 0, 0, 0, 0, P6, 0);
      // Simultaneous rise is suppressed; a lone R re-press then moves right.
      add(1, 0, 0, 0, 0, C, 0);
      repeat (3) add(0, 0, 0, 0, 0, C, 0);
      repeat (6) add(0, 1, 1, 0, 0, C, 0);
      repeat (2) add(0, 1, 0, 0, 0, C, 0);
      repeat (3) add(0, 1, 1, 0, 0, C, 0);
      add(0, 1, 1, 0, 1, C, 0);
      repeat (2) add(0, 1, 1, 0, 0, P4, 0);
      repeat (2) add(0, 0, 0, 0, 0, P4, 0);
      // Button held through reset: silent until released and pressed again.
      repeat (2) add(1, 1, 0, 0, 0, C, 0);
      repeat (5) add(0, 1, 0, 0, 0, C, 0);
      add(0, 0, 0, 0, 0, C, 0);
      repeat (3) add(0, 1, 0, 0, 0, C, 0);
      add(0, 1, 0, 1, 0, C, 0);
      repeat (2) add(0, 1, 0, 0, 0, P6, 0);
      repeat (2) add(0, 0, 0, 0, 0, P6, 0);

      foreach (tbl[i]) begin
         Reset = tbl[i].rst; L_raw = tbl[i].l; R_raw = tbl[i].r;
         step();
         chk($sformatf("row%0d_L", i), 32'(L), 32'(tbl[i].el));
         chk($sformatf("row%0d_R", i), 32'(R), 32'(tbl[i].er));
         chk($sformatf("row%0d_leds", i), 32'(leds), 32'(tbl[i].eleds));
         chk($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].edone));
      end

      // Left exit, with a bounce back off the leftmost light on the way.
      do_reset();
      press(1, C,            9'b000100000, 0);
      press(1, 9'b000100000, 9'b001000000, 0);
      press(1, 9'b001000000, 9'b010000000, 0);
      press(1, 9'b010000000, 9'b100000000, 0);
      press(0, 9'b100000000, 9'b010000000, 0);
      press(1, 9'b010000000, 9'b100000000, 0);
      press(1, 9'b100000000, 9'b000000000, 1);
      for (int i = 0; i < 12; i++) begin
         L_raw = (i % 4) < 2; R_raw = (i % 6) >= 3;
         step();
         chk("out_LR", 32'({L, R}), 32'd0);
         chk("out_leds", 32'(leds), 32'd0);
         chk("out_done", 32'(done), 32'd1);
      end

      // Right exit, then a one-cycle reset recenters and play resumes.
      do_reset();
      press(0, C,            9'b000001000, 0);
      press(0, 9'b000001000, 9'b000000100, 0);
      press(0, 9'b000000100, 9'b000000010, 0);
      press(0, 9'b000000010, 9'b000000001, 0);
      press(0, 9'b000000001, 9'b000000000, 1);
      do_reset();
      press(1, C, 9'b000100000, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
